el2_exu_mul_noc_ctl: RTL and testbench
======================================

# el2_exu_mul_noc_ctl

Core-side sequencer for the multiplier node on the EXU NoC. It accepts one multiply request at a time from the EXU issue logic and drives the serial sender with `{rs1, rs2, mul_p}`. It then waits for the 32-bit result from the serial receiver and holds it for the EXU until it is consumed. It also handles pipeline flush, including discarding a result that is still in flight, and can optionally watchdog a lost response.

## Interface
- `CTL_BITS`, default 18: width of the packed `el2_mul_pkt_t` control field.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles. Used only with `EL2_MUL_NOC_TIMEOUT_EN`. Legal range 2..65535.
- `clk` in 1: EXU NoC clock (`clk_noc` at instantiation). Single clock domain.
- `rst_l` in 1: reset, asynchronous, active-low.
- `flush` in 1: pipeline flush (`noc_sr_flush`).
- `req_valid` in 1: issue request present.
- `req_ready` out 1: controller can accept a request.
- `req_rs1` in 32: operand 1.
- `req_rs2` in 32: operand 2.
- `req_ctl` in CTL_BITS: `mul_p`.
- `snd_enable` out 1: packet valid to the serial sender.
- `snd_packet` out 64+CTL_BITS: `{rs1, rs2, ctl}`, MSB first.
- `snd_ack` in 1: sender has taken the packet.
- `rcv_valid` in 1: result packet delivered by the serial receiver (one-cycle pulse).
- `rcv_result` in 32: result payload.
- `res_valid` out 1: result available to the EXU.
- `res_data` out 32: result.
- `res_ready` in 1: EXU consumes the result.
- `busy` out 1: state is not IDLE, or `drop_pending` is set.
- `timeout_err` out 1: one-cycle pulse on watchdog expiry. Tied 0 without the macro.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE. Internal flag `drop_pending` counts at most one stale result.
- `req_ready` = (state==IDLE) & ~flush. This is combinational.
- **IDLE:** when `req_valid & req_ready`, register operands and ctl, then go to SEND.
- **SEND:**
  - `snd_enable`=1 and `snd_packet` is stable.
  - `snd_ack`=1 goes to WAIT. An ack is not required in the same cycle.
- **WAIT:**
  - `rcv_valid` & `drop_pending`: clear `drop_pending`, discard the payload, remain in WAIT.
  - `rcv_valid` & ~`drop_pending`: capture `rcv_result` into `res_data`, go to DONE.
- **DONE:** `res_valid`=1 and `res_data` is held. `res_ready` returns to IDLE.
- `rcv_valid` in IDLE, SEND or DONE:
  - With `drop_pending`=1, clear it and discard the payload.
  - Otherwise ignore it; `drop_pending` is unchanged.
- Flush has priority over every other transition. Next state is IDLE, and the flush cycle's request is not accepted.
  - Flush in WAIT sets `drop_pending`, because the result is still in flight.
  - If `rcv_valid` coincides with flush in WAIT, that payload is the one being dropped, so `drop_pending` stays 0.
  - Flush in SEND does not set `drop_pending`; the sender flushes its own packet.
  - Flush in DONE discards `res_data` and does not set `drop_pending`.
- A new request may be accepted while `drop_pending`=1. The MUL node is in order, so the first returning result is the stale one.
- Flush in WAIT while `drop_pending`=1 leaves the flag at 1; at most one result is outstanding.

## Timing
- Reset values:
  - state=IDLE, `drop_pending`=0.
  - `snd_enable`=0, `snd_packet`=0.
  - `res_valid`=0, `res_data`=0.
  - `busy`=0, `timeout_err`=0.
  - `req_ready`=1 once `rst_l` deasserts, with no flush.
- Reset mid-operation aborts immediately. Outputs go to their reset values asynchronously, and `drop_pending` is cleared.
- Request accepted on edge 0 gives `snd_enable`=1 during cycle 1.
- With `snd_ack` in cycle 1 the state is WAIT from cycle 2.
- `rcv_valid` in cycle N gives `res_valid`=1 in cycle N+1.
- Minimum latency from acceptance to `res_valid` is 3 cycles plus the remote round trip.
- `res_ready` asserted in the first DONE cycle gives `req_ready`=1 in the next cycle. Throughput is therefore at most one op per 4 cycles plus the round trip.
- All outputs except `req_ready` are registered.

## Configuration
- `EL2_MUL_NOC_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching `TIMEOUT_CYCLES`: next state is IDLE, `drop_pending` is set, and `timeout_err` pulses for 1 cycle.
  - Flush clears the counter.
- Not defined: no counter, WAIT can last indefinitely, and `timeout_err` is constant 0.

## Test plan
- Basic op: rs1=0x0000_0007, rs2=0x0000_0006, ack in cycle 1, `rcv_valid` in cycle 5 with result 0x2A -> `res_valid` in cycle 6 with `res_data`=0x2A, `req_ready` high in the cycle after `res_ready`.
- Sender backpressure: `snd_ack` held low for 4 cycles -> `snd_enable` stays 1 with `snd_packet` unchanged, and the state moves to WAIT only after the ack.
- Flush in WAIT, new op accepted, then two `rcv_valid` pulses (0x1111, 0x2222) -> 0x1111 dropped, `res_data`=0x2222, `drop_pending` back to 0.
- Flush coinciding with `rcv_valid` in WAIT -> `drop_pending`=0, `res_valid` never asserted, `busy`=0 on the next cycle.
- Asynchronous reset asserted in DONE -> `res_valid`, `busy` and `snd_enable` go 0 immediately, and `req_ready`=1 after release.
- With `EL2_MUL_NOC_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no `rcv_valid` -> `timeout_err` pulses once after 8 WAIT cycles, state returns to IDLE, and a late `rcv_valid` is discarded.

Source files
------------

// File: rtl/el2_exu_mul_noc_ctl_if.sv
// Handshake bundle between EXU issue, the NoC serial sender/receiver and the
// multiplier sequencer. The sequencer uses the slave view; the driving side
// (EXU plus serial endpoints) uses the master view.
interface el2_exu_mul_noc_ctl_if #(
  parameter int CTL_BITS = 18
);
  logic                    req_valid;
  logic                    req_ready;
  logic [31:0]             req_rs1;
  logic [31:0]             req_rs2;
  logic [CTL_BITS-1:0]     req_ctl;
  logic                    snd_enable;
  logic [64+CTL_BITS-1:0]  snd_packet;
  logic                    snd_ack;
  logic                    rcv_valid;
  logic [31:0]             rcv_result;
  logic                    res_valid;
  logic [31:0]             res_data;
  logic                    res_ready;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_ctl, snd_ack, rcv_valid, rcv_result, res_ready,
    output req_ready, snd_enable, snd_packet, res_valid, res_data
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_ctl, snd_ack, rcv_valid, rcv_result, res_ready,
    input  req_ready, snd_enable, snd_packet, res_valid, res_data
  );
endinterface

// File: rtl/el2_exu_mul_noc_ctl.sv
// Core-side sequencer for the NoC multiplier node: one request in flight,
// packet out to the serial sender, result back from the serial receiver and
// held until the EXU takes it. A flush while the result is still in flight
// leaves a one-deep "drop_pending" marker so the stale result is discarded.
// Optional response watchdog: define EL2_MUL_NOC_TIMEOUT_EN.
module el2_exu_mul_noc_ctl #(
  parameter int CTL_BITS       = 18,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        flush,
  el2_exu_mul_noc_ctl_if.slave        bus,
  output logic                        busy,
  output logic                        timeout_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   drop_pending, drop_nxt;
  logic   accept, capture, expire, to_fire;

  assign bus.req_ready = (state == IDLE) & ~flush;
  assign accept        = bus.req_valid & bus.req_ready;

`ifdef EL2_MUL_NOC_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;

  // Count cycles spent in WAIT; zero everywhere else, so entry starts at 0.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                        wait_cnt <= '0;
    else if (flush || state != WAIT)   wait_cnt <= '0;
    else                               wait_cnt <= wait_cnt + 16'd1;
  end

  // >= rather than == so a stale drop landing on the limit cycle cannot skip it.
  assign expire = (state == WAIT) && (wait_cnt >= TO_LIM);

  // One-cycle error pulse when the watchdog actually fires.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) timeout_err <= 1'b0;
    else        timeout_err <= to_fire;
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state / drop marker; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_pending;
    capture   = 1'b0;
    to_fire   = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      // In WAIT the live result becomes stale unless it is arriving right now.
      if (state == WAIT) drop_nxt = drop_pending | ~bus.rcv_valid;
      else               drop_nxt = drop_pending & ~bus.rcv_valid;
    end else begin
      // Any returning payload is the stale one while the marker is set.
      if (bus.rcv_valid && drop_pending) drop_nxt = 1'b0;
      unique case (state)
        IDLE: if (bus.req_valid) state_nxt = SEND;
        SEND: if (bus.snd_ack)   state_nxt = WAIT;
        WAIT: begin
          if (bus.rcv_valid) begin
            if (!drop_pending) begin
              capture   = 1'b1;
              state_nxt = DONE;
            end
          end else if (expire) begin
            state_nxt = IDLE;
            drop_nxt  = 1'b1;
            to_fire   = 1'b1;
          end
        end
        DONE: if (bus.res_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and drop marker.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= IDLE;
      drop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      drop_pending <= drop_nxt;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bus.snd_enable <= 1'b0;
      bus.snd_packet <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      busy           <= 1'b0;
    end else begin
      bus.snd_enable <= (state_nxt == SEND);
      bus.res_valid  <= (state_nxt == DONE);
      busy           <= (state_nxt != IDLE) | drop_nxt;
      if (accept)
        bus.snd_packet <= {bus.req_rs1, bus.req_rs2, bus.req_ctl};
      if (capture)
        bus.res_data <= bus.rcv_result;
      else if (flush && state == DONE)
        bus.res_data <= '0;
    end
  end

endmodule

// File: tb/tb_el2_exu_mul_noc_ctl.sv
// Bench for the NoC multiplier sequencer: directed scenarios plus random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_el2_exu_mul_noc_ctl;
  localparam int CB = 18;
  localparam int TO = 8;
`ifdef EL2_MUL_NOC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic flush = 1'b0;
  logic busy, timeout_err;

  el2_exu_mul_noc_ctl_if #(.CTL_BITS(CB)) bus ();

  el2_exu_mul_noc_ctl #(.CTL_BITS(CB), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .flush       (flush),
    .bus         (bus.slave),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: op phase, how many stale results are owed by the node
  // (the node keeps at most one), the last packet sent and last result kept.
  typedef enum int {PH_IDLE, PH_SEND, PH_WAIT, PH_HOLD} phase_t;
  phase_t          ph;
  int              stale;
  logic [81:0]     m_pkt;
  logic [31:0]     m_res;
  int              waited;
  bit              m_to;

  task automatic model_reset();
    ph = PH_IDLE; stale = 0; m_pkt = '0; m_res = '0; waited = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit rv, ate;
    rv = bus.rcv_valid;
    m_to = 0;
    ate = 0;
    if (flush) begin
      if (ph == PH_WAIT) begin
        // Result arriving now is the abandoned one; otherwise it is still owed.
        if (!(rv && stale == 0)) stale = 1;
        else stale = 0;
      end else if (rv && stale > 0) stale = 0;
      if (ph == PH_HOLD) m_res = '0;
      ph = PH_IDLE;
    end else begin
      if (rv && stale > 0) begin stale = 0; ate = 1; end
      case (ph)
        PH_IDLE: if (bus.req_valid) begin
          m_pkt = {bus.req_rs1, bus.req_rs2, bus.req_ctl};
          ph = PH_SEND;
        end
        PH_SEND: if (bus.snd_ack) begin ph = PH_WAIT; waited = 0; end
        PH_WAIT: begin
          waited++;
          if (rv && !ate) begin m_res = bus.rcv_result; ph = PH_HOLD; end
          else if (!rv && TO_EN && waited >= TO) begin
            ph = PH_IDLE; stale = 1; m_to = 1;
          end
        end
        PH_HOLD: if (bus.res_ready) ph = PH_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("snd_enable", bus.snd_enable, ph == PH_SEND);
    chk("snd_packet", bus.snd_packet, m_pkt);
    chk("res_valid", bus.res_valid, ph == PH_HOLD);
    chk("res_data", bus.res_data, m_res);
    chk("busy", busy, (ph != PH_IDLE) || (stale > 0));
    chk("timeout_err", timeout_err, m_to);
    chk("req_ready", bus.req_ready, (ph == PH_IDLE) && !flush);
  endtask

  // One clock: check outputs mid-cycle, then advance model on the edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    bus.req_valid = 0; bus.snd_ack = 0; bus.rcv_valid = 0; bus.res_ready = 0; flush = 0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_ctl = CB'(a ^ b);
    tick();
    bus.req_valid = 0;
  endtask

  task automatic to_wait(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    bus.snd_ack = 1; tick(); bus.snd_ack = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int rcv_pct;
    bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_ctl = 0; bus.rcv_result = 0;
    idle_in();
    model_reset();
    #7;
    chk("rst_snd_enable", bus.snd_enable, 1'b0);
    chk("rst_snd_packet", bus.snd_packet, 82'h0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    @(negedge clk); rst_l = 1;
    @(posedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);

    // Basic op: accept edge 0, ack in cycle 1, result in cycle 5.
    issue(32'h7, 32'h6);
    chk("basic_pkt", bus.snd_packet, {32'h7, 32'h6, CB'(32'h1)});
    bus.snd_ack = 1; tick(); bus.snd_ack = 0;
    tick(); tick(); tick();
    bus.rcv_valid = 1; bus.rcv_result = 32'h2A; tick(); bus.rcv_valid = 0;
    chk("basic_res_valid", bus.res_valid, 1'b1);
    chk("basic_res_data", bus.res_data, 32'h2A);
    bus.res_ready = 1; tick(); bus.res_ready = 0;
    chk("basic_req_ready", bus.req_ready, 1'b1);

    // Sender backpressure: four cycles without ack.
    issue(32'hDEAD_BEEF, 32'h1234_5678);
    repeat (4) tick();
    chk("bp_snd_enable", bus.snd_enable, 1'b1);
    chk("bp_pkt", bus.snd_packet, {32'hDEAD_BEEF, 32'h1234_5678, CB'(32'hDEAD_BEEF ^ 32'h1234_5678)});
    bus.snd_ack = 1; tick(); bus.snd_ack = 0;
    chk("bp_left_send", bus.snd_enable, 1'b0);
    bus.rcv_valid = 1; bus.rcv_result = 32'h55; tick(); bus.rcv_valid = 0;
    bus.res_ready = 1; tick(); bus.res_ready = 0;

    // Flush in WAIT, new op, stale then real result.
    to_wait(32'h3, 32'h4);
    flush = 1; tick(); flush = 0;
    chk("fw_busy_drop", busy, 1'b1);
    to_wait(32'h5, 32'h6);
    bus.rcv_valid = 1; bus.rcv_result = 32'h1111; tick();
    chk("fw_stale_res_valid", bus.res_valid, 1'b0);
    bus.rcv_result = 32'h2222; tick(); bus.rcv_valid = 0;
    chk("fw_res_data", bus.res_data, 32'h2222);
    bus.res_ready = 1; tick(); bus.res_ready = 0;
    chk("fw_busy_clear", busy, 1'b0);

    // Flush coinciding with the result in WAIT.
    to_wait(32'h8, 32'h9);
    flush = 1; bus.rcv_valid = 1; bus.rcv_result = 32'h77; tick();
    flush = 0; bus.rcv_valid = 0;
    chk("frc_busy", busy, 1'b0);
    chk("frc_res_valid", bus.res_valid, 1'b0);
    tick();

    // Asynchronous reset while holding a result.
    to_wait(32'hA, 32'hB);
    bus.rcv_valid = 1; bus.rcv_result = 32'h99; tick(); bus.rcv_valid = 0;
    chk("ar_in_done", bus.res_valid, 1'b1);
    #2 rst_l = 0; #1;
    chk("ar_res_valid", bus.res_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_snd_enable", bus.snd_enable, 1'b0);
    model_reset();
    @(negedge clk); rst_l = 1;
    @(posedge clk); #1;
    chk("ar_req_ready", bus.req_ready, 1'b1);

    // Lost response: watchdog fires only with the feature built in.
    to_wait(32'hC, 32'hD);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (timeout_err === 1'b1) pulses++;
    end
    chk("to_pulses", pulses, TO_EN ? 1 : 0);
    chk("to_busy", busy, 1'b1);
    bus.rcv_valid = 1; bus.rcv_result = 32'hBAD; tick(); bus.rcv_valid = 0;
    if (TO_EN) chk("to_late_dropped", busy, 1'b0);
    else       chk("noto_late_taken", bus.res_valid, 1'b1);
    flush = 1; tick(); flush = 0;
    tick();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rcv_pct = (i < 750) ? 30 : 8;
      bus.req_valid  = $urandom_range(0, 1);
      bus.req_rs1    = $urandom;
      bus.req_rs2    = $urandom;
      bus.req_ctl    = CB'($urandom);
      bus.snd_ack    = ($urandom_range(0, 9) < 4);
      bus.rcv_valid  = ($urandom_range(0, 99) < rcv_pct);
      bus.rcv_result = $urandom;
      bus.res_ready  = $urandom_range(0, 1);
      flush          = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
